// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between NUM_REQ
// requesters. Operands are registered before the ALU and the result after it,
// giving a fixed IDLE -> EXEC -> RESP sequence per operation.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 1,
    parameter int MAX_OP  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*5-1:0]      req_shamt,
    input  logic [NUM_REQ*4-1:0]      req_ctrl,
    output logic [DATA_W-1:0]         alu_in1,
    output logic [DATA_W-1:0]         alu_in2,
    output logic [4:0]                alu_shamt,
    output logic [3:0]                alu_ctrl,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_err,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CTRL = 4'(MAX_OP);

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    last_g;
    logic [ID_W-1:0]    op_id;
    logic [ID_W-1:0]    gnt;
    logic [NUM_REQ-1:0] rot;
    logic               found;
    logic               take;
    int unsigned        pos;
    int unsigned        win;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [4:0]         sel_shamt;
    logic [3:0]         sel_ctrl;

    // Round-robin pick: rotate the doubled valid vector so requester last_g+1
    // sits at bit 0, take the lowest set bit, then map back to an index.
    always_comb begin
        rot   = NUM_REQ'({req_valid, req_valid} >> (32'(last_g) + 32'd1));
        found = 1'b0;
        pos   = 0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pos   = j;
            end
        end
        win = 32'(last_g) + 32'd1 + pos;
        if (win >= NUM_REQ) win = win - NUM_REQ;
        gnt       = ID_W'(win);
        sel_a     = '0;
        sel_b     = '0;
        sel_shamt = '0;
        sel_ctrl  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (win == k) begin
                sel_a     = req_a[k*DATA_W +: DATA_W];
                sel_b     = req_b[k*DATA_W +: DATA_W];
                sel_shamt = req_shamt[k*5 +: 5];
                sel_ctrl  = req_ctrl[k*4 +: 4];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and grant. req_ready is also gated by rst_n so that every
    // output reads zero while reset is held, even with requests pending.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        take      = 1'b0;
        case (state_q)
            IDLE: begin
                if (found && rst_n) begin
                    take    = 1'b1;
                    state_d = EXEC;
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        req_ready[k] = (win == k);
                    end
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);

    // Operand capture on transfer, result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1    <= '0;
            alu_in2    <= '0;
            alu_shamt  <= '0;
            alu_ctrl   <= '0;
            op_id      <= '0;
            last_g     <= ID_W'(NUM_REQ - 1);
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (take) begin
                alu_in1   <= sel_a;
                alu_in2   <= sel_b;
                alu_shamt <= sel_shamt;
                alu_ctrl  <= sel_ctrl;
                op_id     <= gnt;
                last_g    <= gnt;
            end
            if (state_q == EXEC) begin
                rsp_id <= op_id;
                if (alu_ctrl > MAX_CTRL) begin
                    rsp_result <= '0;
                    rsp_zero   <= 1'b1;
                    rsp_err    <= 1'b1;
                end else begin
                    rsp_result <= alu_out;
                    rsp_zero   <= alu_zero;
                    rsp_err    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a behavioural ALU closes the loop,
// and a round-robin/latency model predicts grants and responses.
module tb_alu_share_arbiter;

    localparam int NR = 2;
    localparam int W  = 32;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic [NR*5-1:0] req_shamt;
    logic [NR*4-1:0] req_ctrl;
    logic [W-1:0]    alu_in1;
    logic [W-1:0]    alu_in2;
    logic [4:0]      alu_shamt;
    logic [3:0]      alu_ctrl;
    logic [W-1:0]    alu_out;
    logic            alu_zero;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [0:0]      rsp_id;
    logic [W-1:0]    rsp_result;
    logic            rsp_zero;
    logic            rsp_err;
    logic            busy;

    logic [W-1:0] ra [NR];
    logic [W-1:0] rb [NR];
    logic [4:0]   rs [NR];
    logic [3:0]   rc [NR];

    int checks = 0;
    int errors = 0;
    int last_m = NR - 1;
    int g;
    int rem [NR];

    alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(W), .ID_W(1), .MAX_OP(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .req_ctrl(req_ctrl),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team ALU behaviour: returns {zero, result}. Illegal codes give garbage
    // so that a design forwarding alu_out on an illegal op is caught.
    function automatic logic [32:0] alu_m(input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] s, input logic [3:0] c);
        logic [31:0] r;
        case (c)
            4'd0:  r = x + y;
            4'd1:  r = x - y;
            4'd2:  r = x & y;
            4'd3:  r = x | y;
            4'd4:  r = x ^ y;
            4'd5:  r = ~(x | y);
            4'd6:  r = {31'b0, $signed(x) < $signed(y)};
            4'd7:  r = {31'b0, x < y};
            4'd8:  r = y << s;
            4'd9:  r = y >> s;
            4'd10: r = $signed(y) >>> s;
            4'd11: r = {y[15:0], 16'h0};
            4'd12: r = x & ~y;
            default: r = 32'hdead_beef;
        endcase
        return {(c <= 4'd12) ? (r == 32'd0) : 1'b0, r};
    endfunction

    assign {alu_zero, alu_out} = alu_m(alu_in1, alu_in2, alu_shamt, alu_ctrl);

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            req_a[k*W +: W]   = ra[k];
            req_b[k*W +: W]   = rb[k];
            req_shamt[k*5 +: 5] = rs[k];
            req_ctrl[k*4 +: 4]  = rc[k];
        end
    end

    // Expected response {err, zero, result}.
    function automatic logic [33:0] exp_rsp(input logic [31:0] x, input logic [31:0] y,
                                            input logic [4:0] s, input logic [3:0] c);
        if (c > 4'd12) return {1'b1, 1'b1, 32'd0};
        return {1'b0, alu_m(x, y, s, c)};
    endfunction

    // Round-robin rule: first valid requester after the last winner.
    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        logic [NR-1:0] t;
        for (int o = 1; o <= NR; o++) begin
            int k;
            k = (last + o) % NR;
            t = v >> k;
            if (t[0]) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 0);
        chk({tag, "_rsp_result"}, 64'(rsp_result), 0);
        chk({tag, "_rsp_zero"}, 64'(rsp_zero), 0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_alu_in1"}, 64'(alu_in1), 0);
        chk({tag, "_alu_in2"}, 64'(alu_in2), 0);
        chk({tag, "_alu_shamt"}, 64'(alu_shamt), 0);
        chk({tag, "_alu_ctrl"}, 64'(alu_ctrl), 0);
    endtask

    // One operation starting at an IDLE negedge with requests already driven.
    // Ends at the negedge where the design is back in IDLE.
    task automatic transact(input int stall, input bit rst_mid, output int gw);
        logic [33:0] e;
        logic [31:0] ea, eb;
        logic [4:0]  es;
        logic [3:0]  ec;
        #1;
        gw = rr_pick(req_valid, last_m);
        chk("have_request", 64'(gw >= 0), 1);
        if (gw < 0) return;
        chk("idle_busy", 64'(busy), 0);
        chk("idle_rsp_valid", 64'(rsp_valid), 0);
        chk("grant", 64'(req_ready), 64'(1) << gw);
        ea = ra[gw]; eb = rb[gw]; es = rs[gw]; ec = rc[gw];
        e = exp_rsp(ea, eb, es, ec);
        last_m = gw;
        @(negedge clk);
        req_valid = req_valid & ~(NR'(1) << gw);
        if (stall > 0) rsp_ready = 1'b0;
        chk("exec_busy", 64'(busy), 1);
        chk("exec_rsp_valid", 64'(rsp_valid), 0);
        chk("exec_req_ready", 64'(req_ready), 0);
        chk("exec_alu_in1", 64'(alu_in1), 64'(ea));
        chk("exec_alu_in2", 64'(alu_in2), 64'(eb));
        chk("exec_alu_shamt", 64'(alu_shamt), 64'(es));
        chk("exec_alu_ctrl", 64'(alu_ctrl), 64'(ec));
        if (rst_mid) begin
            rst_n = 1'b0;
            #1;
            chk_zero("mid_reset");
            @(negedge clk);
            rst_n = 1'b1;
            rsp_ready = 1'b1;
            last_m = NR - 1;
            repeat (2) begin
                @(negedge clk);
                chk("post_reset_rsp_valid", 64'(rsp_valid), 0);
                chk("post_reset_busy", 64'(busy), 0);
            end
            return;
        end
        @(negedge clk);
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) @(negedge clk);
            chk("resp_valid", 64'(rsp_valid), 1);
            chk("resp_busy", 64'(busy), 1);
            chk("resp_req_ready", 64'(req_ready), 0);
            chk("resp_id", 64'(rsp_id), 64'(gw));
            chk("resp_result", 64'(rsp_result), 64'(e[31:0]));
            chk("resp_zero", 64'(rsp_zero), 64'(e[32]));
            chk("resp_err", 64'(rsp_err), 64'(e[33]));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("done_rsp_valid", 64'(rsp_valid), 0);
        chk("done_busy", 64'(busy), 0);
    endtask

    task automatic rand_ops(input int k);
        ra[k] = $urandom;
        rb[k] = $urandom;
        rs[k] = 5'($urandom_range(0, 31));
        rc[k] = 4'($urandom_range(0, 12));
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        for (int k = 0; k < NR; k++) rand_ops(k);
        req_valid = '1;
        #2;
        chk_zero("reset");
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset_busy", 64'(busy), 0);
        chk("idle_after_reset_ready", 64'(req_ready), 0);

        // All legal codes from requester 0 with fixed operands.
        for (int c = 0; c <= 12; c++) begin
            ra[0] = 32'd10; rb[0] = 32'd20; rs[0] = 5'd2; rc[0] = 4'(c);
            req_valid = 2'b01;
            transact(0, 1'b0, g);
        end

        // Illegal code from requester 1.
        ra[1] = 32'd10; rb[1] = 32'd20; rs[1] = 5'd0; rc[1] = 4'd13;
        req_valid = 2'b10;
        transact(0, 1'b0, g);

        // Both requesters, four operations each, random operands.
        rem[0] = 4; rem[1] = 4;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < NR; k++) begin
                logic [NR-1:0] t;
                t = req_valid >> k;
                if (rem[k] > 0 && !t[0]) begin
                    rand_ops(k);
                    req_valid = req_valid | (NR'(1) << k);
                end
            end
            transact(0, 1'b0, g);
            if (g >= 0) rem[g]--;
        end
        repeat (2) @(negedge clk);
        chk("drained_busy", 64'(busy), 0);
        chk("drained_ready", 64'(req_ready), 0);

        // Response stall with the other requester waiting.
        rand_ops(0); rand_ops(1);
        req_valid = 2'b11;
        transact(5, 1'b0, g);
        transact(0, 1'b0, g);

        // Subtract to zero.
        ra[0] = 32'd5; rb[0] = 32'd5; rs[0] = 5'd0; rc[0] = 4'd1;
        req_valid = 2'b01;
        transact(0, 1'b0, g);

        // Reset in EXEC, then requester 0 must win the next contest.
        rand_ops(0);
        req_valid = 2'b01;
        transact(0, 1'b1, g);
        rand_ops(0); rand_ops(1);
        req_valid = 2'b11;
        transact(0, 1'b0, g);
        transact(0, 1'b0, g);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
